hls_run_sequencer: RTL
======================

Name: hls_run_sequencer

Overview:
- Sequences one run of an HLS kernel (the Bambu `main` top) through its slave memory port and start/done handshake.
- Preloads kernel memory from a host load FIFO, pulses start_port, counts cycles until done_port, optionally enforces a watchdog, then reads result words back over a valid/ready stream.
- Sits between the host/bench control logic and the kernel. It replaces hand-driven slave signals, which otherwise stay tied to zero.

Parameters:
- ADDR_W, 9, per-channel slave address width (byte address).
- DATA_W, 64, per-channel slave data width; one word per access.
- SIZE_W, 7, per-channel data_ram_size width.
- FIFO_DEPTH, 16, load FIFO depth in words; power of two.
- TIMEOUT_CYCLES, 200000000, watchdog limit in cycles.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load FIFO not full.
- ld_data  in  DATA_W  load word.
- cfg_ld_base  in  ADDR_W  first load byte address.
- cfg_ld_len  in  ADDR_W+1  number of load words.
- cfg_rb_base  in  ADDR_W  first readback byte address.
- cfg_rb_len  in  ADDR_W+1  number of readback words.
- go  in  1  start sequence; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- seq_done  out  1  one-cycle pulse when the sequence ends.
- status  out  2  00 ok, 01 timeout; held until the next go.
- cycles  out  32  kernel cycle count; held until the next go.
- rb_valid  out  1  readback word valid.
- rb_ready  in  1  readback consumer ready.
- rb_data  out  DATA_W  readback word.
- start_port  out  1  kernel start pulse.
- done_port  in  1  kernel done.
- S_oe_ram  out  2  read strobes; bit0 = channel 0.
- S_we_ram  out  2  write strobes.
- S_addr_ram  out  2*ADDR_W  addresses; channel 0 in the low slice.
- S_Wdata_ram  out  2*DATA_W  write data.
- S_data_ram_size  out  2*SIZE_W  access size in bits.
- Sout_Rdata_ram  in  2*DATA_W  read data.
- Sout_DataRdy  in  2  access complete per channel.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE and the FIFO is flushed. All outputs go to 0, except ld_ready, which goes to 1.
- Only channel 0 is used. Channel-1 slices are driven 0 at all times.
- S_data_ram_size[SIZE_W-1:0] = DATA_W whenever a strobe is high, and 0 otherwise.
- Load FIFO:
  - Push when ld_valid & ld_ready. Pushes are accepted in any state.
  - Pop only in LOAD.
  - Simultaneous push and pop on a full FIFO is allowed.
- IDLE: go=1 latches all cfg_* inputs, clears cycles and status, then moves to LOAD. If cfg_ld_len=0 it moves directly to START. go is ignored while busy.
- LOAD:
  - If the FIFO is non-empty and no access is pending, pop the head word and issue the write: S_we_ram[0]=1, addr = cfg_ld_base + i*(DATA_W/8), Wdata = word.
  - Hold all slave outputs stable until Sout_DataRdy[0] is sampled 1. Drop the strobe in the following cycle.
  - An empty FIFO stalls the state with no error.
  - After the cfg_ld_len-th completed write, move to START.
  - Address arithmetic wraps modulo 2^ADDR_W.
- START: start_port=1 for exactly one cycle; cycles is set to 1. done_port is ignored in this state. Next state is RUN.
- RUN:
  - cycles increments every cycle, saturating at 2^32-1.
  - When done_port is sampled 1, that cycle is counted. Then move to READ, or to FIN if cfg_rb_len=0.
- READ:
  - Issue S_oe_ram[0]=1 at cfg_rb_base + j*(DATA_W/8) and hold it until Sout_DataRdy[0]=1.
  - On that cycle, register the read data: rb_data = Sout_Rdata_ram[DATA_W-1:0] and rb_valid=1.
  - Hold rb_valid and rb_data until rb_ready=1. Issue the next read the cycle after the handshake.
  - Only one access is outstanding at a time. After word cfg_rb_len is accepted, move to FIN.
- FIN: seq_done=1 for one cycle, then IDLE.
- A Sout_DataRdy pulse with no strobe pending is ignored.

Optional Feature:
- Macro: HLS_RUN_SEQUENCER_WATCHDOG_EN.
- Defined: in RUN, if cycles reaches TIMEOUT_CYCLES with done_port still 0, set status=01, skip READ, go to FIN. done_port=1 in the limit cycle takes priority and gives status=00.
- Undefined: RUN waits indefinitely for done_port, and status is always 00.

Test Plan:
- Push 4 words 0x11..0x44, cfg_ld_base=0x40, cfg_ld_len=4, DataRdy 2 cycles after each strobe, then go. Expect 4 writes to 0x40, 0x48, 0x50, 0x58 with matching data, then one start_port pulse.
- Hold done_port=1 on the 10th RUN cycle. Expect cycles=11, status=00, and seq_done exactly once.
- cfg_rb_len=3, read data 0xA, 0xB, 0xC, rb_ready low for 5 cycles on the second word. Expect rb_data to hold 0xB and only 3 reads issued.
- go with an empty FIFO and cfg_ld_len=2; push the words 20 cycles later. Expect a stall, then completion; no start_port before the second write completes.
- With the watchdog macro defined, TIMEOUT_CYCLES=50, done_port never asserted. Expect status=01, cycles=50, no reads, seq_done pulse. Then assert reset in READ on a separate run: expect all strobes and rb_valid 0 immediately and ld_ready=1.
- go pulsed during RUN, plus cfg_ld_len=0 and cfg_rb_len=0. Expect the go ignored, LOAD and READ skipped, and a START→RUN→FIN sequence.

Source files
------------

// File: rtl/hls_run_sequencer.sv
// Drives one HLS kernel run: preload memory from a FIFO, pulse start, time the kernel, read back.
// Optional watchdog on the kernel run is enabled by defining HLS_RUN_SEQUENCER_WATCHDOG_EN.
module hls_run_sequencer #(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned SIZE_W         = 7,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic [ADDR_W-1:0]     cfg_ld_base,
  input  logic [ADDR_W:0]       cfg_ld_len,
  input  logic [ADDR_W-1:0]     cfg_rb_base,
  input  logic [ADDR_W:0]       cfg_rb_len,
  input  logic                  go,
  output logic                  busy,
  output logic                  seq_done,
  output logic [1:0]            status,
  output logic [31:0]           cycles,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic [DATA_W-1:0]     rb_data,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W:0] IdxOne = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StRun, StRead, StFin} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q;
  logic                fifo_empty, fifo_full, push, pop;

  logic [ADDR_W:0]     ld_len_q, rb_len_q, idx_q, idx_inc;
  logic [ADDR_W-1:0]   rb_base_q, cur_addr_q, addr_q;
  logic [DATA_W-1:0]   wdata_q, rb_data_q;
  logic                we_q, oe_q, start_q, done_q, rb_valid_q;
  logic [1:0]          status_q;
  logic [31:0]         cycles_q, cycles_inc;
  logic [SIZE_W-1:0]   size_ch0;

  // Load FIFO; a pop frees a slot in the same cycle so a full FIFO can still accept.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign pop        = (state_q == StLoad) && !we_q && !fifo_empty;
  assign ld_ready   = !fifo_full || pop;
  assign push       = ld_valid && ld_ready;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= ld_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: ;
      endcase
    end
  end

  assign idx_inc    = idx_q + IdxOne;
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 32'd1;

`ifdef HLS_RUN_SEQUENCER_WATCHDOG_EN
  localparam logic [31:0] TimeoutLimit = TIMEOUT_CYCLES;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ld_len_q   <= '0;
      rb_len_q   <= '0;
      rb_base_q  <= '0;
      cur_addr_q <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
      cycles_q   <= '0;
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (go) begin
            ld_len_q   <= cfg_ld_len;
            rb_len_q   <= cfg_rb_len;
            rb_base_q  <= cfg_rb_base;
            cur_addr_q <= cfg_ld_base;
            idx_q      <= '0;
            status_q   <= '0;
            if (cfg_ld_len == '0) begin
              state_q  <= StStart;
              start_q  <= 1'b1;
              cycles_q <= 32'd1;
            end else begin
              state_q  <= StLoad;
              cycles_q <= '0;
            end
          end
        end
        StLoad: begin
          if (we_q) begin
            if (Sout_DataRdy[0]) begin
              we_q       <= 1'b0;
              addr_q     <= '0;
              wdata_q    <= '0;
              cur_addr_q <= cur_addr_q + AddrStep;
              idx_q      <= idx_inc;
              if (idx_inc == ld_len_q) begin
                state_q  <= StStart;
                start_q  <= 1'b1;
                cycles_q <= 32'd1;
              end
            end
          end else if (!fifo_empty) begin
            we_q    <= 1'b1;
            addr_q  <= cur_addr_q;
            wdata_q <= fifo_mem[rd_ptr_q];
          end
        end
        StStart: state_q <= StRun;
        StRun: begin
          // The cycle in which done_port is seen is still counted.
          cycles_q <= cycles_inc;
          if (done_port) begin
            if (rb_len_q == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StRead;
              oe_q       <= 1'b1;
              addr_q     <= rb_base_q;
              cur_addr_q <= rb_base_q;
              idx_q      <= '0;
            end
          end
`ifdef HLS_RUN_SEQUENCER_WATCHDOG_EN
          else if (cycles_inc >= TimeoutLimit) begin
            status_q <= 2'b01;
            state_q  <= StFin;
            done_q   <= 1'b1;
          end
`endif
        end
        StRead: begin
          if (oe_q) begin
            if (Sout_DataRdy[0]) begin
              oe_q       <= 1'b0;
              addr_q     <= '0;
              rb_valid_q <= 1'b1;
              rb_data_q  <= Sout_Rdata_ram[DATA_W-1:0];
            end
          end else if (rb_valid_q && rb_ready) begin
            rb_valid_q <= 1'b0;
            idx_q      <= idx_inc;
            if (idx_inc == rb_len_q) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              oe_q       <= 1'b1;
              addr_q     <= cur_addr_q + AddrStep;
              cur_addr_q <= cur_addr_q + AddrStep;
            end
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign size_ch0        = (we_q || oe_q) ? SIZE_W'(DATA_W) : '0;
  assign busy            = (state_q != StIdle);
  assign seq_done        = done_q;
  assign status          = status_q;
  assign cycles          = cycles_q;
  assign rb_valid        = rb_valid_q;
  assign rb_data         = rb_data_q;
  assign start_port      = start_q;
  assign S_oe_ram        = {1'b0, oe_q};
  assign S_we_ram        = {1'b0, we_q};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, size_ch0};

  // Channel 1 is never used.
  logic unused_ch1;
  assign unused_ch1 = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

endmodule
